// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RV32I load/store funct3 encodings, writeback
// result-source selector and the datapath width.
package pipeline_pkg;

    localparam int unsigned DATA_W = 32;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment unit.
//   i_funct3       access size and signedness
//   i_store        access is a store (selects the store legality rules)
//   i_addr_lo      byte offset within the word
//   i_store_data   raw store data (rs2)
//   i_ram_word     word currently read from the data RAM
//   o_byte_en      per-lane write enables
//   o_wdata        store data replicated across lanes
//   o_load_data    selected and sign/zero-extended load value
//   o_misaligned   offset not a multiple of the access size
//   o_unsupported  funct3 has no meaning for this access type
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic              i_store,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_ram_word,
    output logic [3:0]        o_byte_en,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misaligned,
    output logic              o_unsupported
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // Halves are picked by addr[1] only; a misaligned half never reaches writeback.
    assign shifted = i_ram_word >> {i_addr_lo, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = i_addr_lo[1] ? i_ram_word[31:16] : i_ram_word[15:0];

    always_comb begin
        o_byte_en     = 4'b0000;
        o_wdata       = i_store_data;
        o_load_data   = '0;
        o_misaligned  = 1'b0;
        o_unsupported = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_byte_en   = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{ld_byte[7]}}, ld_byte};
            end
            F3_H: begin
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {{16{ld_half[15]}}, ld_half};
                o_misaligned = i_addr_lo[0];
            end
            F3_W: begin
                o_byte_en    = 4'b1111;
                o_load_data  = i_ram_word;
                o_misaligned = |i_addr_lo;
            end
            F3_BU: begin
                o_load_data   = {24'b0, ld_byte};
                o_unsupported = i_store;
            end
            F3_HU: begin
                o_load_data   = {16'b0, ld_half};
                o_misaligned  = i_addr_lo[0];
                o_unsupported = i_store;
            end
            default: begin
                o_unsupported = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_lsu.sv
// MEM stage of the 5-stage RV32I pipeline: byte-writable data RAM, load/store
// alignment, misalignment detection and the MEM/WB pipeline register.
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid                 instruction present in MEM
//   i_memwrite, i_memread   store / load
//   i_funct3                access size and signedness
//   i_alu_result            byte address or ALU value
//   i_write_data            store data
//   i_pc_plus4              link value
//   i_result_src            00 ALU, 01 load, 10 PC+4
//   i_regwrite, i_rd        destination write request
//   i_stall                 hold MEM/WB, defer the RAM write
//   o_valid_w .. o_result_w MEM/WB register towards writeback
//   o_misaligned            one-cycle fault pulse
//   o_misaligned_addr       last faulting address
module mem_wb_lsu
    import pipeline_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH     = 32,
    parameter int unsigned P_ADDR_WIDTH     = 10,
    parameter int unsigned P_REG_ADDR_WIDTH = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    input  logic                        i_memwrite,
    input  logic                        i_memread,
    input  logic [2:0]                  i_funct3,
    input  logic [P_DATA_WIDTH-1:0]     i_alu_result,
    input  logic [P_DATA_WIDTH-1:0]     i_write_data,
    input  logic [P_DATA_WIDTH-1:0]     i_pc_plus4,
    input  logic [1:0]                  i_result_src,
    input  logic                        i_regwrite,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                        i_stall,
    output logic                        o_valid_w,
    output logic                        o_regwrite_w,
    output logic [P_REG_ADDR_WIDTH-1:0] o_rd_w,
    output logic [P_DATA_WIDTH-1:0]     o_result_w,
    output logic                        o_misaligned,
    output logic [P_DATA_WIDTH-1:0]     o_misaligned_addr
);

    logic [P_DATA_WIDTH-1:0] l_ram [2**P_ADDR_WIDTH];

    logic [P_ADDR_WIDTH-1:0] word_idx;
    logic [P_DATA_WIDTH-1:0] ram_word;
    logic [3:0]              byte_en;
    logic [P_DATA_WIDTH-1:0] wdata;
    logic [P_DATA_WIDTH-1:0] load_data;
    logic                    align_mis;
    logic                    align_unsup;
    logic                    mem_access;
    logic                    unsupported;
    logic                    fault;
    logic                    ram_we;
    logic [P_DATA_WIDTH-1:0] result_d;
    logic                    regwrite_d;

    logic                        valid_q;
    logic                        regwrite_q;
    logic [P_REG_ADDR_WIDTH-1:0] rd_q;
    logic [P_DATA_WIDTH-1:0]     result_q;
    logic                        mis_q;
    logic [P_DATA_WIDTH-1:0]     mis_addr_q;

    // Address bits above the RAM are ignored, so the address space wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_alu_result[P_DATA_WIDTH-1:P_ADDR_WIDTH+2];

    assign word_idx = i_alu_result[P_ADDR_WIDTH+1:2];
    assign ram_word = l_ram[word_idx];

    lsu_align u_align (
        .i_funct3      (i_funct3),
        .i_store       (i_memwrite),
        .i_addr_lo     (i_alu_result[1:0]),
        .i_store_data  (i_write_data),
        .i_ram_word    (ram_word),
        .o_byte_en     (byte_en),
        .o_wdata       (wdata),
        .o_load_data   (load_data),
        .o_misaligned  (align_mis),
        .o_unsupported (align_unsup)
    );

    // funct3 only carries access meaning for loads and stores.
    assign mem_access  = i_memread | i_memwrite;
    assign unsupported = mem_access & align_unsup;
    assign fault       = i_valid & mem_access & align_mis & ~unsupported;
    // Gating with i_rst_n blocks a store caught by a mid-cycle reset.
    assign ram_we      = i_valid & i_memwrite & ~align_mis & ~unsupported & ~i_stall & i_rst_n;

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    l_ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        result_d = '0;
        case (i_result_src)
            RES_ALU: result_d = i_alu_result;
            RES_MEM: result_d = load_data;
            RES_PC4: result_d = i_pc_plus4;
            default: result_d = '0;
        endcase
    end

    assign regwrite_d = i_valid & i_regwrite & (i_rd != '0) & ~fault & ~unsupported;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else if (i_stall) begin
            mis_q <= 1'b0;
        end else begin
            valid_q    <= i_valid;
            regwrite_q <= regwrite_d;
            rd_q       <= i_rd;
            result_q   <= result_d;
            mis_q      <= fault;
            if (fault) begin
                mis_addr_q <= i_alu_result;
            end
        end
    end

    assign o_valid_w         = valid_q;
    assign o_regwrite_w      = regwrite_q;
    assign o_rd_w            = rd_q;
    assign o_result_w        = result_q;
    assign o_misaligned      = mis_q;
    assign o_misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Scoreboard bench for mem_wb_lsu: stimulus pushes expected MEM/WB contents
// computed from a byte-array memory model; a negedge monitor pops and compares.
module tb_mem_wb_lsu;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] alu_result = 32'b0;
    logic [31:0] write_data = 32'b0;
    logic [31:0] pc_plus4 = 32'b0;
    logic [1:0]  result_src = 2'b0;
    logic        regwrite = 1'b0;
    logic [4:0]  rd_i = 5'b0;
    logic        stall = 1'b0;
    logic        o_valid_w;
    logic        o_regwrite_w;
    logic [4:0]  o_rd_w;
    logic [31:0] o_result_w;
    logic        o_misaligned;
    logic [31:0] o_misaligned_addr;

    mem_wb_lsu dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_valid           (valid),
        .i_memwrite        (memwrite),
        .i_memread         (memread),
        .i_funct3          (funct3),
        .i_alu_result      (alu_result),
        .i_write_data      (write_data),
        .i_pc_plus4        (pc_plus4),
        .i_result_src      (result_src),
        .i_regwrite        (regwrite),
        .i_rd              (rd_i),
        .i_stall           (stall),
        .o_valid_w         (o_valid_w),
        .o_regwrite_w      (o_regwrite_w),
        .o_rd_w            (o_rd_w),
        .o_result_w        (o_result_w),
        .o_misaligned      (o_misaligned),
        .o_misaligned_addr (o_misaligned_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        chk;
        logic        mis;
        logic [31:0] mis_addr;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp = '0;
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  mem [4096];
    logic [31:0] m_mis_addr = 32'b0;
    logic        stall_at_edge = 1'b0;
    logic        rst_at_edge = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [11:0] a);
        logic [31:0] v;
        int sz;
        v = 32'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 32'b0;
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem[(int'(a) + i) % 4096];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [11:0] a);
        return {mem[{a[11:2], 2'd3}], mem[{a[11:2], 2'd2}], mem[{a[11:2], 2'd1}],
                mem[{a[11:2], 2'd0}]};
    endfunction

    task automatic idle();
        @(posedge clk); #1;
        valid = 1'b0; memread = 1'b0; memwrite = 1'b0; stall = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] rs,
                         input logic rw, input logic [4:0] rd, input int n_stall,
                         input logic use_exp, input logic [31:0] exp_val);
        exp_t        e;
        logic [11:0] a;
        int          sz;
        logic        unsup;
        logic        misal;
        logic [31:0] pc4;
        @(posedge clk); #1;
        pc4 = $urandom;
        a = addr[11:0];
        valid = 1'b1; memread = ld; memwrite = st; funct3 = f3; alu_result = addr;
        write_data = wd; pc_plus4 = pc4; result_src = rs; regwrite = rw; rd_i = rd;
        stall = (n_stall > 0);
        for (int i = 0; i < n_stall; i++) begin
            @(posedge clk); #1;
            check("stall_ram_unchanged", dut.l_ram[a[11:2]], model_word(a));
        end
        stall = 1'b0;
        sz = 1 << f3[1:0];
        unsup = (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && f3 >= 3'd3);
        misal = (int'(a) % sz) != 0;
        e.v = 1'b1;
        e.rd = rd;
        e.mis = (ld || st) && !unsup && misal;
        e.rw = rw && (rd != 5'd0) && !e.mis && !unsup;
        e.chk = !(rs == 2'b01 && misal);
        case (rs)
            2'b00: e.res = addr;
            2'b01: e.res = model_load(f3, a);
            2'b10: e.res = pc4;
            default: e.res = 32'b0;
        endcase
        if (use_exp) e.res = exp_val;
        if (e.mis) m_mis_addr = addr;
        e.mis_addr = m_mis_addr;
        if (st && !unsup && !misal) begin
            for (int i = 0; i < sz; i++) mem[int'(a) + i] = wd[8*i +: 8];
        end
        q.push_back(e);
    endtask

    task automatic st_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(1'b0, 1'b1, f3, addr, wd, 2'b00, 1'b0, 5'd0, 0, 1'b0, 32'b0);
    endtask

    task automatic ld_op(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] exp_val);
        issue(1'b1, 1'b0, f3, addr, $urandom, 2'b01, 1'b1, rd, 0, 1'b1, exp_val);
    endtask

    always @(posedge clk) begin
        stall_at_edge = stall;
        rst_at_edge = rst_n;
    end

    // Monitor: a new MEM/WB value is presented after every unstalled edge with o_valid_w.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !rst_at_edge) begin
            last_exp = '0;
        end else if (stall_at_edge) begin
            check("stall_valid_hold", {31'b0, o_valid_w}, {31'b0, last_exp.v});
            check("stall_mis_clear", {31'b0, o_misaligned}, 32'b0);
            check("stall_mis_addr_hold", o_misaligned_addr, last_exp.mis_addr);
            if (last_exp.v) begin
                check("stall_rd_hold", {27'b0, o_rd_w}, {27'b0, last_exp.rd});
                check("stall_rw_hold", {31'b0, o_regwrite_w}, {31'b0, last_exp.rw});
                if (last_exp.chk) check("stall_result_hold", o_result_w, last_exp.res);
            end
        end else if (o_valid_w) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got valid result %h expected none", o_result_w);
            end else begin
                e = q.pop_front();
                check("regwrite", {31'b0, o_regwrite_w}, {31'b0, e.rw});
                check("rd", {27'b0, o_rd_w}, {27'b0, e.rd});
                if (e.chk) check("result", o_result_w, e.res);
                check("misaligned", {31'b0, o_misaligned}, {31'b0, e.mis});
                check("misaligned_addr", o_misaligned_addr, e.mis_addr);
                last_exp = e;
            end
        end else begin
            check("idle_misaligned", {31'b0, o_misaligned}, 32'b0);
            check("idle_regwrite", {31'b0, o_regwrite_w}, 32'b0);
            check("idle_mis_addr", o_misaligned_addr, last_exp.mis_addr);
            last_exp.v = 1'b0;
        end
    end

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        int          kind;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, o_valid_w}, 32'b0);
        check("reset_result", o_result_w, 32'b0);
        check("reset_mis_addr", o_misaligned_addr, 32'b0);
        rst_n = 1'b1;

        // Give the model a known image of the low 256 bytes.
        for (int w = 0; w < 64; w++) st_op(F3_W, 32'(w * 4), $urandom);

        st_op(F3_W, 32'd100, 32'd25);
        ld_op(F3_W, 32'd100, 5'd5, 32'd25);

        st_op(F3_W, 32'h60, 32'h1122_3344);
        st_op(F3_B, 32'h61, 32'h0000_00AB);
        ld_op(F3_W, 32'h60, 5'd1, 32'h1122_AB44);
        ld_op(F3_H, 32'h62, 5'd2, 32'h0000_1122);

        st_op(F3_B, 32'h70, 32'h0000_0080);
        ld_op(F3_B, 32'h70, 5'd3, 32'hFFFF_FF80);
        ld_op(F3_BU, 32'h70, 5'd4, 32'h0000_0080);
        st_op(F3_H, 32'h72, 32'h0000_8001);
        ld_op(F3_H, 32'h72, 5'd5, 32'hFFFF_8001);

        st_op(F3_W, 32'h63, 32'hDEAD_BEEF);
        ld_op(F3_W, 32'h60, 5'd6, 32'h1122_AB44);
        issue(1'b1, 1'b0, F3_W, 32'h61, 32'b0, 2'b01, 1'b1, 5'd6, 0, 1'b0, 32'b0);

        ld_op(F3_W, 32'h60, 5'd7, 32'h1122_AB44);
        issue(1'b0, 1'b1, F3_W, 32'h40, 32'd7, 2'b00, 1'b0, 5'd0, 3, 1'b0, 32'b0);
        ld_op(F3_W, 32'h40, 5'd8, 32'd7);

        st_op(F3_W, 32'h44, 32'h5555_AAAA);
        idle();
        idle();
        @(posedge clk); #1;
        valid = 1'b1; memwrite = 1'b1; memread = 1'b0; funct3 = F3_W; alu_result = 32'h44;
        write_data = 32'd9; result_src = 2'b00; regwrite = 1'b0; rd_i = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, o_valid_w}, 32'b0);
        check("rst_async_regwrite", {31'b0, o_regwrite_w}, 32'b0);
        check("rst_async_rd", {27'b0, o_rd_w}, 32'b0);
        check("rst_async_result", o_result_w, 32'b0);
        check("rst_async_mis", {31'b0, o_misaligned}, 32'b0);
        check("rst_async_mis_addr", o_misaligned_addr, 32'b0);
        @(posedge clk); #1;
        valid = 1'b0; memwrite = 1'b0;
        rst_n = 1'b1;
        m_mis_addr = 32'b0;
        ld_op(F3_W, 32'h44, 5'd10, 32'h5555_AAAA);
        ld_op(F3_W, 32'h44, 5'd0, 32'h5555_AAAA);

        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            f3 = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_F0FF);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            if (kind < 4) begin
                issue(1'b1, 1'b0, f3, addr, $urandom, 2'b01, 1'($urandom), 5'($urandom),
                      ($urandom_range(0, 5) == 0) ? 1 : 0, 1'b0, 32'b0);
            end else if (kind < 7) begin
                issue(1'b0, 1'b1, f3, addr, $urandom, 2'b00, 1'($urandom), 5'($urandom),
                      ($urandom_range(0, 5) == 0) ? 2 : 0, 1'b0, 32'b0);
            end else if (kind < 9) begin
                issue(1'b0, 1'b0, f3, addr, $urandom, 2'($urandom), 1'($urandom),
                      5'($urandom), 0, 1'b0, 32'b0);
            end else begin
                idle();
            end
        end

        idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        @(negedge clk); #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
